// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: blank pattern, positive-logic hex glyphs
// and the nibble type used by both the display driver and the capture block.
package seven_seg_pkg;

    typedef logic [3:0] nibble_t;

    // Raw pin value with every active-low segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    function automatic logic [6:0] nibble_to_seg(input nibble_t n);
        logic [6:0] seg;
        case (n)
            4'h0:    seg = SEG_HEX_0;
            4'h1:    seg = SEG_HEX_1;
            4'h2:    seg = SEG_HEX_2;
            4'h3:    seg = SEG_HEX_3;
            4'h4:    seg = SEG_HEX_4;
            4'h5:    seg = SEG_HEX_5;
            4'h6:    seg = SEG_HEX_6;
            4'h7:    seg = SEG_HEX_7;
            4'h8:    seg = SEG_HEX_8;
            4'h9:    seg = SEG_HEX_9;
            4'hA:    seg = SEG_HEX_A;
            4'hB:    seg = SEG_HEX_B;
            4'hC:    seg = SEG_HEX_C;
            4'hD:    seg = SEG_HEX_D;
            4'hE:    seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/segments_to_digit.sv
// Combinational inverse of the hex glyph table: positive-logic segments to
// nibble, with hit low when the pattern is not one of the sixteen glyphs.
module segments_to_digit
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);

    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == nibble_to_seg(nibble_t'(i))) begin
                nibble = nibble_t'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Passive reader for the two-digit multiplexed seven-segment PMOD bus.
// Define SEVEN_SEG_CAPTURE_TIMEOUT_EN to build the idle counter behind `stale`.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pmod,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       stale
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
    // Registers that hold pin history reset to a blank display so that
    // reset itself never looks like a lit digit.
    localparam logic [7:0]       IDLE_PINS = {1'b0, SEG_BLANK};

    if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("seven_seg_capture: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    logic [7:0]       sync_p0;
    logic [7:0]       sync_p1;
    logic [7:0]       prev_p2;
    logic [CNT_W-1:0] cnt_p2;
    logic [CNT_W-1:0] cnt_next;
    logic             armed_p2;
    logic             armed_eff;
    logic             blank;
    logic             changed;
    logic             accept;
    logic [6:0]       seg_pos;
    logic [3:0]       dec_nibble;
    logic             dec_hit;
    logic [3:0]       lo_reg;
    logic             have_lo;

    // stage p0/p1: two-flop synchroniser on all eight pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= IDLE_PINS;
            sync_p1 <= IDLE_PINS;
        end else begin
            sync_p0 <= pmod;
            sync_p1 <= sync_p0;
        end
    end

    assign blank   = (sync_p1[6:0] == SEG_BLANK);
    assign changed = (sync_p1 != prev_p2);

    always_comb begin
        cnt_next  = cnt_p2;
        armed_eff = armed_p2;
        if (blank) begin
            cnt_next  = '0;
            armed_eff = 1'b1;
        end else if (changed) begin
            cnt_next  = CNT_W'(1);
            armed_eff = 1'b1;
        end else if (cnt_p2 != CNT_MAX) begin
            cnt_next  = cnt_p2 + 1'b1;
        end
    end

    assign accept  = armed_eff && (cnt_next == CNT_MAX);
    assign seg_pos = ~sync_p1[6:0];

    segments_to_digit u_dec (
        .seg    (seg_pos),
        .nibble (dec_nibble),
        .hit    (dec_hit)
    );

    // stage p2: stability counter, one-shot arm flag and previous sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_p2  <= IDLE_PINS;
            cnt_p2   <= '0;
            armed_p2 <= 1'b1;
        end else begin
            prev_p2  <= sync_p1;
            cnt_p2   <= cnt_next;
            armed_p2 <= armed_eff & ~accept;
        end
    end

    // stage p3: digit pairing and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= 8'h00;
            valid   <= 1'b0;
            err     <= 1'b0;
            lo_reg  <= 4'h0;
            have_lo <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (accept) begin
                if (!dec_hit) begin
                    err     <= 1'b1;
                    have_lo <= 1'b0;
                end else if (sync_p1[7]) begin
                    lo_reg  <= dec_nibble;
                    have_lo <= 1'b1;
                end else if (have_lo) begin
                    data    <= {dec_nibble, lo_reg};
                    valid   <= 1'b1;
                    have_lo <= 1'b0;
                end
            end
        end
    end

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign stale = (idle_cnt == IDLE_MAX);
`else
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with a run-length reference model
// compared every cycle, plus literal expectations per scenario.
module tb_seven_seg_capture;

    localparam int         S     = 4;
    localparam int         T     = 32;
    localparam logic [7:0] BLANK = 8'h7F;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pmod  = BLANK;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       stale;

    seven_seg_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pmod  (pmod),
        .data  (data),
        .valid (valid),
        .err   (err),
        .stale (stale)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int valid_cnt   = 0;
    int err_cnt     = 0;
    int last_valid_cyc = -1;

    // reference model state
    logic [7:0] m_data;
    logic       m_valid, m_err, m_stale;
    logic [7:0] ph0, ph1, last_s, m_s;
    int         run, idle, nib;
    logic       m_have_lo;
    logic [3:0] m_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int seg_index(input logic [6:0] seg);
        for (int i = 0; i < 16; i++)
            if (HEX[i] == seg) return i;
        return -1;
    endfunction

    function automatic logic [7:0] lo(input logic [6:0] seg);
        return {1'b1, ~seg};
    endfunction

    function automatic logic [7:0] hi(input logic [6:0] seg);
        return {1'b0, ~seg};
    endfunction

    task automatic model_reset();
        ph0 = BLANK; ph1 = BLANK; last_s = BLANK;
        run = 0; idle = 0;
        m_data = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_stale = 1'b0;
        m_have_lo = 1'b0; m_lo = 4'h0;
    endtask

    // Model: a digit is accepted when the synced sample (pins seen two edges
    // earlier) has been the same non-blank value for exactly S cycles.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                model_reset();
            end else begin
                m_s = ph1; ph1 = ph0; ph0 = pmod;
                m_valid = 1'b0;
                m_err   = 1'b0;
                if (m_s[6:0] == 7'h7F) run = 0;
                else if (m_s == last_s) run++;
                else run = 1;
                last_s = m_s;
                if (run == S) begin
                    idle = 0;
                    nib  = seg_index(~m_s[6:0]);
                    if (nib < 0) begin
                        m_err = 1'b1; m_have_lo = 1'b0;
                    end else if (m_s[7]) begin
                        m_lo = nib[3:0]; m_have_lo = 1'b1;
                    end else if (m_have_lo) begin
                        m_data = {nib[3:0], m_lo}; m_valid = 1'b1; m_have_lo = 1'b0;
                    end
                end else if (idle < T) begin
                    idle++;
                end
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
                m_stale = (idle == T);
`else
                m_stale = 1'b0;
`endif
            end
        end
    end

    // Per-cycle comparison away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("data",  32'(data),  32'(m_data));
                check("valid", 32'(valid), 32'(m_valid));
                check("err",   32'(err),   32'(m_err));
                check("stale", 32'(stale), 32'(m_stale));
                check("valid_err_exclusive", 32'(valid & err), 32'd0);
                if (valid) begin valid_cnt++; last_valid_cyc = cyc; end
                if (err) err_cnt++;
            end
        end
    end

    task automatic hold(input logic [7:0] v, input int n);
        pmod = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int v0, e0, settle;

    initial begin
        rst_n = 1'b0;
        pmod  = BLANK;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_data",  32'(data),  32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_err",   32'(err),   32'd0);
        check("reset_stale", 32'(stale), 32'd0);

        // Frame 0xA5 with latency pin
        v0 = valid_cnt; e0 = err_cnt;
        hold(lo(7'h6D), 20);
        hold(BLANK, 10);
        settle = cyc;
        hold(hi(7'h77), 20);
        check("frame_data",        32'(data), 32'hA5);
        check("frame_valid_count", valid_cnt - v0, 1);
        check("frame_err_count",   err_cnt - e0, 0);
        check("frame_latency",     last_valid_cyc - settle, 6);

        // Glitch filter: 3-cycle runs never reach S=4
        v0 = valid_cnt; e0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            hold(lo(7'h06), 3);
            hold(lo(7'h5B), 3);
        end
        hold(hi(7'h4F), 3);
        hold(BLANK, 4);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_err",   err_cnt - e0, 0);
        hold(lo(7'h06), 10);
        hold(hi(7'h4F), 10);
        check("glitch_then_data", 32'(data), 32'h31);
        check("glitch_then_valid_count", valid_cnt - v0, 1);

        // Invalid high pattern
        v0 = valid_cnt; e0 = err_cnt;
        hold(lo(7'h06), 10);
        hold(hi(7'h41), 10);
        check("invalid_err_count",   err_cnt - e0, 1);
        check("invalid_valid_count", valid_cnt - v0, 0);
        check("invalid_data_kept",   32'(data), 32'h31);
        hold(hi(7'h3F), 10);
        check("after_invalid_no_valid", valid_cnt - v0, 0);

        // Orphan high, then double low
        v0 = valid_cnt; e0 = err_cnt;
        hold(hi(7'h7F), 10);
        check("orphan_no_valid", valid_cnt - v0, 0);
        check("orphan_no_err",   err_cnt - e0, 0);
        hold(lo(7'h3F), 10);
        hold(lo(7'h7F), 10);
        hold(hi(7'h66), 10);
        check("double_low_data",  32'(data), 32'h48);
        check("double_low_valid", valid_cnt - v0, 1);

        // Reset mid-frame
        hold(lo(7'h06), 10);
        pmod  = hi(7'h66);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        v0 = valid_cnt; e0 = err_cnt;
        check("midreset_data",  32'(data),  32'h00);
        check("midreset_valid", 32'(valid), 32'd0);
        hold(hi(7'h66), 10);
        check("midreset_no_valid", valid_cnt - v0, 0);
        check("midreset_no_err",   err_cnt - e0, 0);
        check("midreset_data_after", 32'(data), 32'h00);

        // Idle period, then a fresh accept
        hold(BLANK, 40);
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
        check("timeout_stale_set", 32'(stale), 32'd1);
`else
        check("timeout_stale_tied", 32'(stale), 32'd0);
`endif
        hold(lo(7'h06), 10);
        check("timeout_stale_cleared", 32'(stale), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
